// File: rtl/store_queue_arbiter_if.sv
// Shared size type and the bundled memory-stage / dbus signal set for store_queue_arbiter.
// slave is the arbiter's view; master is the view of the memory stage plus the bus model.
package store_queue_arbiter_pkg;
   typedef enum logic [1:0] {
      MSIZE1 = 2'd0,
      MSIZE2 = 2'd1,
      MSIZE4 = 2'd2,
      MSIZE8 = 2'd3
   } msize_t;
endpackage

interface store_queue_arbiter_if;
   import store_queue_arbiter_pkg::*;

   logic        st_valid;
   logic [63:0] st_addr;
   logic [63:0] st_data;
   msize_t      st_msize;
   logic        st_ready;

   logic        ld_valid;
   logic [63:0] ld_addr;
   msize_t      ld_msize;
   logic        ld_done;
   logic [63:0] ld_rdata;

   logic        dreq_valid;
   logic [63:0] dreq_addr;
   logic        dreq_write;
   msize_t      dreq_size;
   logic [63:0] dreq_data;
   logic [7:0]  dreq_strobe;
   logic        dresp_ok;
   logic [63:0] dresp_data;

   logic        sq_empty;

   modport slave (
      input  st_valid, st_addr, st_data, st_msize,
      input  ld_valid, ld_addr, ld_msize,
      input  dresp_ok, dresp_data,
      output st_ready, ld_done, ld_rdata,
      output dreq_valid, dreq_addr, dreq_write, dreq_size, dreq_data, dreq_strobe,
      output sq_empty
   );

   modport master (
      output st_valid, st_addr, st_data, st_msize,
      output ld_valid, ld_addr, ld_msize,
      output dresp_ok, dresp_data,
      input  st_ready, ld_done, ld_rdata,
      input  dreq_valid, dreq_addr, dreq_write, dreq_size, dreq_data, dreq_strobe,
      input  sq_empty
   );
endinterface

// File: rtl/store_queue_arbiter.sv
// Shares the memory-stage dbus port between loads and a FIFO of committed, lane-steered stores.
// Define STQ_MERGE_EN to coalesce a store into the youngest queued entry of the same 8-byte word.
module store_queue_arbiter
   import store_queue_arbiter_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input logic                  clk,
   input logic                  reset,
   store_queue_arbiter_if.slave bus
);
   localparam int PW = $clog2(DEPTH);
   localparam logic [PW:0] FULL_COUNT = (PW+1)'(DEPTH);

   typedef enum logic [1:0] {IDLE, LOAD, STORE} state_t;

   state_t        state_q, state_d;
   logic [63:0]   ent_addr_q   [DEPTH];
   logic [63:0]   ent_addr_d   [DEPTH];
   logic [63:0]   ent_data_q   [DEPTH];
   logic [63:0]   ent_data_d   [DEPTH];
   logic [7:0]    ent_strobe_q [DEPTH];
   logic [7:0]    ent_strobe_d [DEPTH];
   msize_t        ent_msize_q  [DEPTH];
   msize_t        ent_msize_d  [DEPTH];
   logic [PW-1:0] head_q, head_d, tail_q, tail_d;
   logic [PW:0]   count_q, count_d;

   logic          dreq_valid_q, dreq_valid_d;
   logic [63:0]   dreq_addr_q, dreq_addr_d;
   logic          dreq_write_q, dreq_write_d;
   msize_t        dreq_size_q, dreq_size_d;
   logic [63:0]   dreq_data_q, dreq_data_d;
   logic [7:0]    dreq_strobe_q, dreq_strobe_d;
   logic          ld_done_q, ld_done_d;
   logic [63:0]   ld_rdata_q, ld_rdata_d;

   logic [63:0]    st_beat;
   logic [7:0]     st_strb;
   logic [DEPTH-1:0] ent_valid;
   logic           conflict, full, launch_load, launch_store;
   logic           merge_hit, push, pop;

   // Narrow stores are replicated across the beat so the strobe alone picks the lanes.
   always_comb begin
      st_beat = bus.st_data;
      st_strb = 8'hff;
      case (bus.st_msize)
         MSIZE1: begin
            st_beat = {8{bus.st_data[7:0]}};
            st_strb = 8'h01 << bus.st_addr[2:0];
         end
         MSIZE2: begin
            st_beat = {4{bus.st_data[15:0]}};
            st_strb = 8'h03 << {bus.st_addr[2:1], 1'b0};
         end
         MSIZE4: begin
            st_beat = {2{bus.st_data[31:0]}};
            st_strb = bus.st_addr[2] ? 8'hf0 : 8'h0f;
         end
         default: begin
            st_beat = bus.st_data;
            st_strb = 8'hff;
         end
      endcase
   end

   always_comb begin
      conflict = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
         ent_valid[i] = {1'b0, PW'(i) - head_q} < count_q;
         if (ent_valid[i] && (ent_addr_q[i][63:3] == bus.ld_addr[63:3])) begin
            conflict = 1'b1;
         end
      end
   end

   assign full         = (count_q == FULL_COUNT);
   assign launch_load  = (state_q == IDLE) && bus.ld_valid && !conflict && !full;
   assign launch_store = (state_q == IDLE) && !launch_load && (count_q != '0);

`ifdef STQ_MERGE_EN
   logic [PW-1:0] young_idx;
   assign young_idx = tail_q - PW'(1);
   // The head must not change under a request that has been, or is about to be, issued.
   assign merge_hit = bus.st_valid && (count_q != '0)
                    && (ent_addr_q[young_idx][63:3] == bus.st_addr[63:3])
                    && !((young_idx == head_q) && ((state_q == STORE) || launch_store));
`else
   assign merge_hit = 1'b0;
`endif

   assign bus.st_ready = !full || merge_hit;
   assign push         = bus.st_valid && !full && !merge_hit;
   assign pop          = (state_q == STORE) && bus.dresp_ok;

   always_comb begin
      ent_addr_d   = ent_addr_q;
      ent_data_d   = ent_data_q;
      ent_strobe_d = ent_strobe_q;
      ent_msize_d  = ent_msize_q;
      head_d       = head_q + PW'(pop);
      tail_d       = tail_q + PW'(push);
      count_d      = count_q + (PW+1)'(push) - (PW+1)'(pop);
      if (push) begin
         ent_addr_d[tail_q]   = bus.st_addr;
         ent_data_d[tail_q]   = st_beat;
         ent_strobe_d[tail_q] = st_strb;
         ent_msize_d[tail_q]  = bus.st_msize;
      end
`ifdef STQ_MERGE_EN
      if (merge_hit) begin
         for (int b = 0; b < 8; b++) begin
            if (st_strb[b]) begin
               ent_data_d[young_idx][8*b +: 8] = st_beat[8*b +: 8];
            end
         end
         ent_strobe_d[young_idx] = ent_strobe_q[young_idx] | st_strb;
         ent_msize_d[young_idx]  = MSIZE8;
         ent_addr_d[young_idx]   = {bus.st_addr[63:3], 3'b000};
      end
`endif
   end

   // Request fields are captured once at issue and held until the bus answers.
   always_comb begin
      state_d       = state_q;
      dreq_valid_d  = dreq_valid_q;
      dreq_addr_d   = dreq_addr_q;
      dreq_write_d  = dreq_write_q;
      dreq_size_d   = dreq_size_q;
      dreq_data_d   = dreq_data_q;
      dreq_strobe_d = dreq_strobe_q;
      ld_done_d     = 1'b0;
      ld_rdata_d    = ld_rdata_q;
      case (state_q)
         IDLE: begin
            if (launch_load) begin
               state_d       = LOAD;
               dreq_valid_d  = 1'b1;
               dreq_addr_d   = bus.ld_addr;
               dreq_write_d  = 1'b0;
               dreq_size_d   = bus.ld_msize;
               dreq_data_d   = '0;
               dreq_strobe_d = '0;
            end else if (launch_store) begin
               state_d       = STORE;
               dreq_valid_d  = 1'b1;
               dreq_addr_d   = ent_addr_q[head_q];
               dreq_write_d  = 1'b1;
               dreq_size_d   = ent_msize_q[head_q];
               dreq_data_d   = ent_data_q[head_q];
               dreq_strobe_d = ent_strobe_q[head_q];
            end
         end
         LOAD: begin
            if (bus.dresp_ok) begin
               state_d       = IDLE;
               dreq_valid_d  = 1'b0;
               dreq_strobe_d = '0;
               ld_done_d     = 1'b1;
               ld_rdata_d    = bus.dresp_data;
            end
         end
         STORE: begin
            if (bus.dresp_ok) begin
               state_d       = IDLE;
               dreq_valid_d  = 1'b0;
               dreq_strobe_d = '0;
            end
         end
         default: begin
            state_d      = IDLE;
            dreq_valid_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q       <= IDLE;
         head_q        <= '0;
         tail_q        <= '0;
         count_q       <= '0;
         dreq_valid_q  <= 1'b0;
         dreq_addr_q   <= '0;
         dreq_write_q  <= 1'b0;
         dreq_size_q   <= MSIZE1;
         dreq_data_q   <= '0;
         dreq_strobe_q <= '0;
         ld_done_q     <= 1'b0;
         ld_rdata_q    <= '0;
      end else begin
         state_q       <= state_d;
         head_q        <= head_d;
         tail_q        <= tail_d;
         count_q       <= count_d;
         ent_addr_q    <= ent_addr_d;
         ent_data_q    <= ent_data_d;
         ent_strobe_q  <= ent_strobe_d;
         ent_msize_q   <= ent_msize_d;
         dreq_valid_q  <= dreq_valid_d;
         dreq_addr_q   <= dreq_addr_d;
         dreq_write_q  <= dreq_write_d;
         dreq_size_q   <= dreq_size_d;
         dreq_data_q   <= dreq_data_d;
         dreq_strobe_q <= dreq_strobe_d;
         ld_done_q     <= ld_done_d;
         ld_rdata_q    <= ld_rdata_d;
      end
   end

   assign bus.dreq_valid  = dreq_valid_q;
   assign bus.dreq_addr   = dreq_addr_q;
   assign bus.dreq_write  = dreq_write_q;
   assign bus.dreq_size   = dreq_size_q;
   assign bus.dreq_data   = dreq_data_q;
   assign bus.dreq_strobe = dreq_strobe_q;
   assign bus.ld_done     = ld_done_q;
   assign bus.ld_rdata    = ld_rdata_q;
   assign bus.sq_empty    = (count_q == '0) && (state_q != STORE);
endmodule

// File: tb/tb_store_queue_arbiter.sv
// Directed and randomized checks of store_queue_arbiter against a transaction-level store/load model.
// Merge expectations follow STQ_MERGE_EN in the same way as the design.
module tb_store_queue_arbiter;
   import store_queue_arbiter_pkg::*;

   localparam int DEPTH = 4;

   typedef struct {
      logic [63:0] addr;
      logic [63:0] data;
      logic [7:0]  strb;
      msize_t      size;
   } beat_t;

   logic clk = 1'b0;
   logic reset;
   int   tests = 0;
   int   fails = 0;

   store_queue_arbiter_if bus ();

   store_queue_arbiter #(.DEPTH(DEPTH)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_output(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic idle_inputs();
      bus.st_valid   = 1'b0;
      bus.st_addr    = '0;
      bus.st_data    = '0;
      bus.st_msize   = MSIZE1;
      bus.ld_valid   = 1'b0;
      bus.ld_addr    = '0;
      bus.ld_msize   = MSIZE1;
      bus.dresp_ok   = 1'b0;
      bus.dresp_data = '0;
   endtask

   task automatic offer_store(input logic [63:0] a, input logic [63:0] d, input msize_t s);
      bus.st_valid = 1'b1;
      bus.st_addr  = a;
      bus.st_data  = d;
      bus.st_msize = s;
   endtask

   task automatic enqueue(input string tag, input logic [63:0] a, input logic [63:0] d, input msize_t s);
      offer_store(a, d, s);
      #1;
      check_output({tag, "_st_ready"}, 64'(bus.st_ready), 64'd1);
      tick();
      bus.st_valid = 1'b0;
      bus.st_addr  = '0;
   endtask

   task automatic wait_req(input string tag);
      int n;
      n = 0;
      while (!bus.dreq_valid && n < 20) begin
         tick();
         n++;
      end
      check_output({tag, "_req_seen"}, 64'(bus.dreq_valid), 64'd1);
   endtask

   task automatic respond(input logic [63:0] d);
      bus.dresp_ok   = 1'b1;
      bus.dresp_data = d;
      tick();
      bus.dresp_ok   = 1'b0;
      bus.dresp_data = '0;
   endtask

   // Spec-level steering: byte j of the store lands in lane (addr mod 8) + j.
   function automatic beat_t model_store(input logic [63:0] a, input logic [63:0] d, input msize_t s);
      beat_t e;
      int n;
      int lane0;
      n       = 1 << int'(s);
      lane0   = int'(a[2:0]);
      e.addr  = a;
      e.size  = s;
      e.strb  = '0;
      e.data  = '0;
      for (int j = 0; j < n; j++) begin
         e.strb[lane0 + j]          = 1'b1;
         e.data[8*(lane0 + j) +: 8] = d[8*j +: 8];
      end
      return e;
   endfunction

   function automatic logic [63:0] lane_mask(input logic [7:0] s);
      logic [63:0] m;
      for (int b = 0; b < 8; b++) m[8*b +: 8] = {8{s[b]}};
      return m;
   endfunction

   beat_t       mq[$];
   beat_t       acc_beat;
   bit          pending_accept, pending_pop, pushed_now, expect_done, in_flight, ld_active, hit;
   int          lat, kst;
   logic [63:0] last_rdata, cur_ld_addr;
   msize_t      rs;
   int          rn;

   initial begin
      idle_inputs();
      reset = 1'b1;
      offer_store(64'h1000, 64'h1234, MSIZE8);
      repeat (2) @(posedge clk);
      #1;
      check_output("rst_dreq_valid", 64'(bus.dreq_valid), 64'd0);
      check_output("rst_st_ready", 64'(bus.st_ready), 64'd1);
      check_output("rst_sq_empty", 64'(bus.sq_empty), 64'd1);
      check_output("rst_ld_done", 64'(bus.ld_done), 64'd0);
      check_output("rst_strobe", 64'(bus.dreq_strobe), 64'd0);
      check_output("rst_ld_rdata", bus.ld_rdata, 64'd0);
      reset = 1'b0;
      idle_inputs();
      tick();
      check_output("rst_no_enqueue", 64'(bus.sq_empty), 64'd1);
      tick();
      check_output("rst_no_request", 64'(bus.dreq_valid), 64'd0);

      enqueue("sb", 64'h1003, 64'hAB, MSIZE1);
      wait_req("sb");
      check_output("sb_write", 64'(bus.dreq_write), 64'd1);
      check_output("sb_addr", bus.dreq_addr, 64'h1003);
      check_output("sb_strobe", 64'(bus.dreq_strobe), 64'h08);
      check_output("sb_lane", 64'(bus.dreq_data[31:24]), 64'hAB);
      check_output("sb_size", 64'(bus.dreq_size), 64'(MSIZE1));
      respond('0);
      check_output("sb_done_valid", 64'(bus.dreq_valid), 64'd0);
      check_output("sb_done_empty", 64'(bus.sq_empty), 64'd1);

      enqueue("sw", 64'h1004, 64'h11223344, MSIZE4);
      wait_req("sw");
      check_output("sw_strobe", 64'(bus.dreq_strobe), 64'hf0);
      check_output("sw_lane", 64'(bus.dreq_data[63:32]), 64'h11223344);
      respond('0);

      offer_store(64'h2000, 64'hA0A0, MSIZE8);
      tick();
      offer_store(64'h2008, 64'hB0B0, MSIZE8);
      bus.ld_valid = 1'b1;
      bus.ld_addr  = 64'h3000;
      bus.ld_msize = MSIZE8;
      tick();
      bus.st_valid = 1'b0;
      wait_req("ldpri");
      check_output("ldpri_is_load", 64'(bus.dreq_write), 64'd0);
      check_output("ldpri_addr", bus.dreq_addr, 64'h3000);
      check_output("ldpri_strobe", 64'(bus.dreq_strobe), 64'd0);
      respond(64'hDEADBEEFCAFEF00D);
      check_output("ldpri_done", 64'(bus.ld_done), 64'd1);
      check_output("ldpri_rdata", bus.ld_rdata, 64'hDEADBEEFCAFEF00D);
      bus.ld_valid = 1'b0;
      tick();
      check_output("ldpri_done_pulse", 64'(bus.ld_done), 64'd0);
      wait_req("ldpri_st0");
      check_output("ldpri_st0_addr", bus.dreq_addr, 64'h2000);
      check_output("ldpri_st0_data", bus.dreq_data, 64'hA0A0);
      respond('0);
      wait_req("ldpri_st1");
      check_output("ldpri_st1_addr", bus.dreq_addr, 64'h2008);
      respond('0);
      check_output("ldpri_empty", 64'(bus.sq_empty), 64'd1);

      enqueue("cf_s0", 64'h4100, 64'h1, MSIZE8);
      wait_req("cf_s0");
      enqueue("cf_sd", 64'h4008, 64'h5555, MSIZE8);
      bus.ld_valid = 1'b1;
      bus.ld_addr  = 64'h400C;
      bus.ld_msize = MSIZE4;
      tick();
      tick();
      check_output("cf_s0_stable", bus.dreq_addr, 64'h4100);
      respond('0);
      wait_req("cf_sd");
      check_output("cf_store_first", 64'(bus.dreq_write), 64'd1);
      check_output("cf_store_addr", bus.dreq_addr, 64'h4008);
      tick();
      tick();
      check_output("cf_load_waits", 64'(bus.ld_done), 64'd0);
      respond('0);
      wait_req("cf_ld");
      check_output("cf_ld_is_load", 64'(bus.dreq_write), 64'd0);
      check_output("cf_ld_addr", bus.dreq_addr, 64'h400C);
      check_output("cf_ld_size", 64'(bus.dreq_size), 64'(MSIZE4));
      respond(64'h0123456789ABCDEF);
      check_output("cf_ld_rdata", bus.ld_rdata, 64'h0123456789ABCDEF);
      bus.ld_valid = 1'b0;

      for (int i = 0; i < DEPTH; i++) enqueue("full_fill", 64'h6000 + 64'(8*i), 64'(i), MSIZE8);
      check_output("full_not_ready", 64'(bus.st_ready), 64'd0);
      offer_store(64'h7000, 64'h77, MSIZE8);
      tick();
      tick();
      check_output("full_refused", 64'(bus.st_ready), 64'd0);
      check_output("full_head_addr", bus.dreq_addr, 64'h6000);
      respond('0);
      check_output("full_one_slot", 64'(bus.st_ready), 64'd1);
      tick();
      bus.st_valid = 1'b0;
      #1;
      check_output("full_again", 64'(bus.st_ready), 64'd0);
      for (int i = 1; i <= DEPTH; i++) begin
         wait_req("full_drain");
         check_output("full_drain_addr", bus.dreq_addr, (i == DEPTH) ? 64'h7000 : 64'h6000 + 64'(8*i));
         respond('0);
      end
      check_output("full_empty", 64'(bus.sq_empty), 64'd1);

      enqueue("mg_busy", 64'h8000, 64'h0, MSIZE8);
      wait_req("mg_busy");
      enqueue("mg_sb0", 64'h5001, 64'h11, MSIZE1);
      enqueue("mg_sb1", 64'h5006, 64'h22, MSIZE1);
      respond('0);
      wait_req("mg_w0");
`ifdef STQ_MERGE_EN
      check_output("mg_addr", bus.dreq_addr, 64'h5000);
      check_output("mg_strobe", 64'(bus.dreq_strobe), 64'h42);
      check_output("mg_size", 64'(bus.dreq_size), 64'(MSIZE8));
      check_output("mg_byte1", 64'(bus.dreq_data[15:8]), 64'h11);
      check_output("mg_byte6", 64'(bus.dreq_data[55:48]), 64'h22);
      respond('0);
      tick();
      tick();
      check_output("mg_single_write", 64'(bus.dreq_valid), 64'd0);
`else
      check_output("nomg_w0_addr", bus.dreq_addr, 64'h5001);
      check_output("nomg_w0_strobe", 64'(bus.dreq_strobe), 64'h02);
      check_output("nomg_w0_byte", 64'(bus.dreq_data[15:8]), 64'h11);
      respond('0);
      wait_req("nomg_w1");
      check_output("nomg_w1_addr", bus.dreq_addr, 64'h5006);
      check_output("nomg_w1_strobe", 64'(bus.dreq_strobe), 64'h40);
      check_output("nomg_w1_byte", 64'(bus.dreq_data[55:48]), 64'h22);
      respond('0);
`endif
      check_output("mg_empty", 64'(bus.sq_empty), 64'd1);

      // Randomized traffic: consecutive stores always hit different words, so no merging occurs.
      idle_inputs();
      pending_accept = 0;
      pending_pop    = 0;
      expect_done    = 0;
      in_flight      = 0;
      ld_active      = 0;
      lat            = 0;
      kst            = 0;
      last_rdata     = '0;
      cur_ld_addr    = '0;
      for (int cyc = 0; cyc < 600; cyc++) begin
         pushed_now = 0;
         if (pending_pop) begin
            void'(mq.pop_front());
            pending_pop = 0;
         end
         if (pending_accept) begin
            mq.push_back(acc_beat);
            pushed_now     = 1;
            pending_accept = 0;
         end
         check_output("rnd_ld_done", 64'(bus.ld_done), 64'(expect_done));
         if (expect_done) begin
            check_output("rnd_ld_rdata", bus.ld_rdata, last_rdata);
            ld_active    = 0;
            bus.ld_valid = 1'b0;
         end
         expect_done    = 0;
         bus.dresp_ok   = 1'b0;
         bus.dresp_data = '0;
         if (bus.dreq_valid && !in_flight) begin
            in_flight = 1;
            lat       = $urandom_range(0, 3);
            if (bus.dreq_write) begin
               check_output("rnd_wr_expected", 64'(mq.size() != 0), 64'd1);
               if (mq.size() != 0) begin
                  check_output("rnd_wr_addr", bus.dreq_addr, mq[0].addr);
                  check_output("rnd_wr_strobe", 64'(bus.dreq_strobe), 64'(mq[0].strb));
                  check_output("rnd_wr_data", bus.dreq_data & lane_mask(mq[0].strb), mq[0].data);
                  check_output("rnd_wr_size", 64'(bus.dreq_size), 64'(mq[0].size));
               end
            end else begin
               check_output("rnd_ld_addr", bus.dreq_addr, cur_ld_addr);
               check_output("rnd_ld_strobe", 64'(bus.dreq_strobe), 64'd0);
               hit = 0;
               for (int i = 0; i < mq.size(); i++) begin
                  if (!(pushed_now && i == mq.size() - 1) && mq[i].addr[63:3] == cur_ld_addr[63:3]) hit = 1;
               end
               check_output("rnd_ld_no_conflict", 64'(hit), 64'd0);
            end
         end
         if (in_flight) begin
            if (lat == 0) begin
               bus.dresp_ok   = 1'b1;
               bus.dresp_data = {$urandom, $urandom};
               in_flight      = 0;
               if (bus.dreq_write) pending_pop = 1;
               else begin
                  expect_done = 1;
                  last_rdata  = bus.dresp_data;
               end
            end else begin
               lat--;
            end
         end
         if (!ld_active && cyc < 350 && $urandom_range(0, 3) == 0) begin
            rs           = msize_t'(2'($urandom_range(0, 3)));
            rn           = 1 << int'(rs);
            cur_ld_addr  = 64'h9000 + 64'(8 * $urandom_range(0, 15)) + 64'(rn * $urandom_range(0, 8 / rn - 1));
            bus.ld_valid = 1'b1;
            bus.ld_addr  = cur_ld_addr;
            bus.ld_msize = rs;
            ld_active    = 1;
         end
         if (!(bus.st_valid && !pushed_now)) begin
            if (cyc < 350 && $urandom_range(0, 1) == 1) begin
               rs = msize_t'(2'($urandom_range(0, 3)));
               rn = 1 << int'(rs);
               offer_store(64'h9000 + 64'(8 * (kst % 16)) + 64'(rn * $urandom_range(0, 8 / rn - 1)),
                           {$urandom, $urandom}, rs);
               kst++;
            end else begin
               bus.st_valid = 1'b0;
               bus.st_addr  = '0;
            end
         end
         #1;
         check_output("rnd_st_ready", 64'(bus.st_ready), 64'(mq.size() < DEPTH));
         if (bus.st_valid && bus.st_ready) begin
            pending_accept = 1;
            acc_beat       = model_store(bus.st_addr, bus.st_data, bus.st_msize);
         end
         tick();
      end
      check_output("rnd_model_drained", 64'(mq.size()), 64'd0);
      check_output("rnd_load_finished", 64'(ld_active), 64'd0);
      check_output("rnd_sq_empty", 64'(bus.sq_empty), 64'd1);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
